// File: rtl/debug_ctrl.sv
// Board debug controller: CPU clock-enable generation (RUN/STEP), key debouncing and
// paged 16-bit debug channel view. Define DEBUG_BREAK_EN to add the pc breakpoint ports.
module debug_ctrl #(
    parameter int unsigned DIV = 6_000_000,
    parameter int unsigned NCH = 4,
    parameter int unsigned DW  = 16,
    parameter int unsigned DEB = 50_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              key_step_n,
    input  logic              key_mode_n,
    input  logic              key_page_n,
    input  logic [NCH*DW-1:0] ch_data,
`ifdef DEBUG_BREAK_EN
    input  logic              bp_valid,
    input  logic [DW-1:0]     bp_addr,
    output logic              bp_hit,
`endif
    output logic              cpu_en,
    output logic              run_mode,
    output logic [7:0]        page,
    output logic [23:0]       disp_nib,
    output logic [15:0]       step_cnt
);

    localparam int unsigned CW  = $clog2(DEB + 1);
    localparam int unsigned DVW = $clog2(DIV + 1);

    localparam logic [0:0] ST_STEP = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // key index: 0 = step, 1 = mode, 2 = page
    logic [2:0]    keys;
    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    deb;
    logic [2:0]    press;
    logic [CW-1:0] cnt [3];

    logic [0:0]     state;
    logic [0:0]     state_next;
    logic [DVW-1:0] div_cnt;
    logic [DVW-1:0] div_next;
    logic           en_next;
    logic           bp_trig;
    logic [DW-1:0]  sel;
    logic [15:0]    sel16;

    assign keys     = {key_page_n, key_mode_n, key_step_n};
    assign run_mode = (state == ST_RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '1;
            sync2 <= '1;
            deb   <= '1;
            press <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= keys;
            sync2 <= sync1;
            for (int unsigned i = 0; i < 3; i++) begin
                press[i] <= 1'b0;
                if (sync2[i] != deb[i]) begin
                    if (cnt[i] == CW'(DEB - 1)) begin
                        deb[i]   <= sync2[i];
                        cnt[i]   <= '0;
                        press[i] <= ~sync2[i];
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

`ifdef DEBUG_BREAK_EN
    assign bp_trig = (state == ST_RUN) && cpu_en && bp_valid && (ch_data[DW-1:0] == bp_addr);
`else
    assign bp_trig = 1'b0;
`endif

    // A mode press (or breakpoint) pre-empts both the divider pulse and a same-cycle step.
    always_comb begin
        state_next = state;
        div_next   = div_cnt;
        en_next    = 1'b0;
        if (bp_trig) begin
            state_next = ST_STEP;
            div_next   = '0;
        end else if (press[1]) begin
            state_next = ~state;
            div_next   = '0;
        end else if (state == ST_RUN) begin
            en_next  = (div_cnt == DVW'(DIV - 1));
            div_next = (div_cnt == DVW'(DIV - 1)) ? '0 : div_cnt + 1'b1;
        end else begin
            en_next = press[0];
        end
    end

    always_comb begin
        sel = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (page == 8'(i)) begin
                sel = ch_data[i*DW +: DW];
            end
        end
        sel16          = '0;
        sel16[DW-1:0]  = sel;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_STEP;
            div_cnt  <= '0;
            cpu_en   <= 1'b0;
            step_cnt <= '0;
            page     <= '0;
        end else begin
            state    <= state_next;
            div_cnt  <= div_next;
            cpu_en   <= en_next;
            step_cnt <= step_cnt + 16'(en_next);
            if (press[2]) begin
                page <= (page == 8'(NCH - 1)) ? '0 : page + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            disp_nib <= {8'h00, 16'(ch_data[DW-1:0])};
        end else begin
            disp_nib <= {page, sel16};
        end
    end

`ifdef DEBUG_BREAK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            bp_hit <= 1'b0;
        end else if (bp_trig) begin
            bp_hit <= 1'b1;
        end else if (press[1] || press[0]) begin
            bp_hit <= 1'b0;
        end
    end
`endif

endmodule
